// File: rtl/abh_sequencer_if.sv
// Bus-side signal bundle for abh_sequencer: request/mode/ready inputs and
// the address-high select, status and cycle-count outputs.
interface abh_sequencer_if #(
    parameter int CYC_W = 3
) ();
    logic             START;
    logic [2:0]       MODE;
    logic             RDY;
    logic             PAGE_CROSS;
    logic [2:0]       CNTL;
    logic             ABH_INC;
    logic             BUSY;
    logic             DONE;
    logic             ERR;
    logic [CYC_W-1:0] CYCLES;

    modport master (
        output START, MODE, RDY, PAGE_CROSS,
        input  CNTL, ABH_INC, BUSY, DONE, ERR, CYCLES
    );

    modport slave (
        input  START, MODE, RDY, PAGE_CROSS,
        output CNTL, ABH_INC, BUSY, DONE, ERR, CYCLES
    );
endinterface

// File: rtl/abh_sequencer.sv
// Address-high sequencer: steps through the bus cycles of each addressing
// mode, selecting the ADH source and requesting page-cross increments.
module abh_sequencer #(
    parameter int CYC_W = 3
) (
    input logic           CLK,
    input logic           RST_N,
    abh_sequencer_if.slave bus
);
    localparam logic [2:0] M_ABS     = 3'd0;
    localparam logic [2:0] M_ABS_IDX = 3'd1;
    localparam logic [2:0] M_ZP      = 3'd2;
    localparam logic [2:0] M_STACK   = 3'd3;
    localparam logic [2:0] M_IND     = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_LO, S_FETCH_HI, S_OPER, S_FIXUP,
        S_PTR_LO, S_PTR_HI, S_ZPAGE, S_STACK
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic             pc_q, pc_d;
    logic [CYC_W-1:0] cycles_q, cycles_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [2:0]       cntl;
    logic             abh_inc;
    logic             busy;

    // NOTE: state registers use non-blocking assignments only; the reset is
    // sampled on the clock edge, so it sits inside the clocked branch.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            mode_q   <= 3'd0;
            pc_q     <= 1'b0;
            cycles_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            pc_q     <= pc_d;
            cycles_q <= cycles_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        pc_d     = pc_q;
        cycles_d = cycles_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (bus.RDY) begin
            if (state_q == S_IDLE) begin
                if (bus.START) begin
                    mode_d   = bus.MODE;
                    cycles_d = '0;
                    case (bus.MODE)
                        M_ABS, M_ABS_IDX, M_ZP, M_IND: state_d = S_FETCH_LO;
                        M_STACK:                       state_d = S_STACK;
                        default: begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    endcase
                end
            end else begin
                if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
                case (state_q)
                    S_FETCH_LO: state_d = (mode_q == M_ZP) ? S_ZPAGE : S_FETCH_HI;
                    S_FETCH_HI: state_d = (mode_q == M_IND) ? S_PTR_LO : S_OPER;
                    S_PTR_LO: begin
                        pc_d    = bus.PAGE_CROSS;
                        state_d = S_PTR_HI;
                    end
                    S_PTR_HI:   state_d = S_OPER;
                    S_OPER: begin
                        if (mode_q == M_ABS_IDX && bus.PAGE_CROSS) begin
                            state_d = S_FIXUP;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        cntl    = 3'b000;
        abh_inc = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_FETCH_LO, S_FETCH_HI:      cntl = 3'b001;
            S_OPER, S_PTR_LO:            cntl = 3'b010;
            S_FIXUP: begin
                cntl    = 3'b010;
                abh_inc = 1'b1;
            end
            S_PTR_HI: begin
                cntl    = 3'b010;
                abh_inc = pc_q;
            end
            S_STACK:                     cntl = 3'b100;
            default:                     cntl = 3'b000;
        endcase
    end

    assign bus.CNTL    = cntl;
    assign bus.ABH_INC = abh_inc;
    assign bus.BUSY    = busy;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;
    assign bus.CYCLES  = cycles_q;
endmodule
